jt5205_seq: RTL and testbench



---
 rtl/jt5205_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_jt5205_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt5205_seq.sv
// ADPCM playback sequencer: rate-select enables for jt5205, ROM fetch with one-byte prefetch, nibble feed high-first.
// Enables are combinational from cen; din/control registered; ROM stalls surface as zero-nibble underruns with sticky err.
module jt5205_seq #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [1:0]    sel,
   input  logic          start,
   input  logic          stop,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] end_addr,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic          cen_hf,
   output logic          cen_lo,
   output logic [3:0]    din,
   output logic          adpcm_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PLAY  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [6:0]      cnt;
   logic [6:0]      pm1;
   logic            run;
   logic            wrap;
   logic            tick;
   logic [AW-1:0]   end_q;
   logic            guard;
   logic            accept;
   logic [7:0]      cur;
   logic            cur_last;
   logic            half;
   logic [7:0]      next_byte;
   logic            next_vld;
   logic            addr_is_end;

   logic            take_first;
   logic            take_next;
   logic            tick_hi;
   logic            tick_end;
   logic            tick_load;
   logic            tick_under;

   // ---------------------------------------------------------------
   // Sample-rate divider
   // ---------------------------------------------------------------
   always_comb begin
      pm1 = 7'd47;
      case (sel)
         2'd0:    pm1 = 7'd95;
         2'd1:    pm1 = 7'd63;
         2'd2:    pm1 = 7'd47;
         default: pm1 = 7'd47;
      endcase
   end

   assign run    = (sel != 2'd3);
   assign wrap   = (cnt >= pm1);
   assign cen_hf = cen & run;
   assign cen_lo = cen & run & wrap;
   assign tick   = cen_lo;

   // >= rather than == so shortening the period mid-count wraps at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 7'd0;
      end else if (cen) begin
         if (!run || wrap) cnt <= 7'd0;
         else              cnt <= cnt + 7'd1;
      end
   end

   // ---------------------------------------------------------------
   // ROM handshake: rom_ok is ignored the cycle a new address appears
   // ---------------------------------------------------------------
   assign accept      = rom_cs & rom_ok & ~guard;
   assign addr_is_end = (rom_addr == end_q);

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      take_first = 1'b0;
      take_next  = 1'b0;
      tick_hi    = 1'b0;
      tick_end   = 1'b0;
      tick_load  = 1'b0;
      tick_under = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
      end else if (start) begin
         state_nxt = FETCH;
      end else begin
         case (state)
            FETCH: begin
               if (accept) begin
                  take_first = 1'b1;
                  state_nxt  = PLAY;
               end
            end
            PLAY: begin
               take_next = accept;
               if (tick) begin
                  if (half) begin
                     tick_hi = 1'b1;
                  end else if (cur_last) begin
                     tick_end  = 1'b1;
                     state_nxt = IDLE;
                  end else if (next_vld) begin
                     tick_load = 1'b1;
                  end else begin
                     tick_under = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Datapath: fetch address, byte buffers, nibble output, status
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr  <= '0;
         rom_cs    <= 1'b0;
         end_q     <= '0;
         guard     <= 1'b0;
         cur       <= 8'd0;
         cur_last  <= 1'b0;
         half      <= 1'b0;
         next_byte <= 8'd0;
         next_vld  <= 1'b0;
         din       <= 4'd0;
         adpcm_rst <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done  <= 1'b0;
         guard <= 1'b0;
         if (stop) begin
            rom_cs    <= 1'b0;
            adpcm_rst <= 1'b1;
            busy      <= 1'b0;
            din       <= 4'd0;
            half      <= 1'b0;
            next_vld  <= 1'b0;
         end else if (start) begin
            // restart drops any in-flight byte; guard masks a stale rom_ok
            rom_addr  <= start_addr;
            end_q     <= end_addr;
            rom_cs    <= 1'b1;
            guard     <= 1'b1;
            err       <= 1'b0;
            busy      <= 1'b1;
            adpcm_rst <= 1'b1;
            din       <= 4'd0;
            half      <= 1'b0;
            next_vld  <= 1'b0;
         end else begin
            if (take_first) begin
               cur       <= rom_data;
               din       <= rom_data[7:4];
               half      <= 1'b1;
               adpcm_rst <= 1'b0;
               cur_last  <= addr_is_end;
               if (!addr_is_end) begin
                  rom_addr <= rom_addr + AW'(1);
                  guard    <= 1'b1;
               end else begin
                  rom_cs <= 1'b0;
               end
            end
            if (take_next) begin
               next_byte <= rom_data;
               next_vld  <= 1'b1;
               rom_cs    <= 1'b0;
            end
            if (tick_hi) begin
               din  <= cur[3:0];
               half <= 1'b0;
            end
            if (tick_end) begin
               done      <= 1'b1;
               adpcm_rst <= 1'b1;
               busy      <= 1'b0;
               din       <= 4'd0;
            end
            // rom_addr still names the buffered byte when it is promoted
            if (tick_load) begin
               cur      <= next_byte;
               din      <= next_byte[7:4];
               half     <= 1'b1;
               next_vld <= 1'b0;
               cur_last <= addr_is_end;
               if (!addr_is_end) begin
                  rom_addr <= rom_addr + AW'(1);
                  rom_cs   <= 1'b1;
                  guard    <= 1'b1;
               end
            end
            if (tick_under) begin
               din <= 4'd0;
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jt5205_seq.sv
// Directed bench for jt5205_seq: divider periods, playback nibble order, ROM guard, underrun, control and wrap.
module tb_jt5205_seq;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cen;
   logic [1:0]    sel;
   logic          start;
   logic          stop;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] rom_addr;
   logic          rom_cs;
   logic [7:0]    rom_data;
   logic          rom_ok;
   logic          cen_hf;
   logic          cen_lo;
   logic [3:0]    din;
   logic          adpcm_rst;
   logic          busy;
   logic          done;
   logic          err;

   int vectors = 0;
   int miscompares = 0;

   // ROM model: data registered one cycle behind the address, ok after lat stable cycles
   int            lat = 2;
   logic          force_ok = 1'b0;
   int            wcnt = 0;
   logic [AW-1:0] last_addr = '0;
   logic [7:0]    rom_q = 8'd0;

   always #5 clk = ~clk;

   jt5205_seq #(.AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .sel        (sel),
      .start      (start),
      .stop       (stop),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .rom_addr   (rom_addr),
      .rom_cs     (rom_cs),
      .rom_data   (rom_data),
      .rom_ok     (rom_ok),
      .cen_hf     (cen_hf),
      .cen_lo     (cen_lo),
      .din        (din),
      .adpcm_rst  (adpcm_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
      logic [7:0] v;
      case (a)
         16'h0100: v = 8'h3A;
         16'h0101: v = 8'h5C;
         16'h0200: v = 8'h71;
         16'h0201: v = 8'h9E;
         16'h0300: v = 8'hB4;
         16'h0301: v = 8'hD6;
         16'hFFFF: v = 8'h12;
         16'h0000: v = 8'h48;
         default:  v = a[7:0] ^ 8'hA5;
      endcase
      return v;
   endfunction

   always @(posedge clk) begin
      rom_q     <= rom_byte(rom_addr);
      last_addr <= rom_addr;
      if (!rom_cs || rom_addr != last_addr) wcnt <= 0;
      else                                  wcnt <= wcnt + 1;
   end
   assign rom_data = rom_q;
   assign rom_ok   = force_ok | (rom_cs && rom_addr == last_addr && wcnt >= lat);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // counts cens up to and including the next cen_lo, then steps past it
   task automatic count_lo(input string tag, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         n++;
         if (cen_lo === 1'b1) break;
         @(negedge clk);
      end
      @(negedge clk);
      check(tag, n, exp);
   endtask

   task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
      start_addr = s;
      end_addr   = e;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 400 && seen == 0; i++) begin
         if (cen_lo === 1'b1 && adpcm_rst === 1'b0) seen = 1;
         @(negedge clk);
      end
      check(tag, seen, 1);
   endtask

   // records din on decoder ticks until done; gap = cycles from last tick to done
   task automatic play(input int maxcyc, input logic [AW-1:0] bad_addr,
                       output logic [31:0] nibs, output int nn, output int gap,
                       output logic hit_bad);
      int last_tick;
      nibs = '0; nn = 0; gap = -1; last_tick = -1000; hit_bad = 1'b0;
      for (int i = 0; i < maxcyc; i++) begin
         if (rom_cs === 1'b1 && rom_addr === bad_addr) hit_bad = 1'b1;
         if (done === 1'b1) begin
            gap = i - last_tick;
            break;
         end
         if (cen_lo === 1'b1 && adpcm_rst === 1'b0) begin
            nibs = {nibs[27:0], din};
            nn++;
            last_tick = i;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] nibs;
      logic [31:0] exp_nibs;
      int          nn;
      int          gap;
      int          cnt_seen;
      logic        hit_bad;

      rst = 1'b1; cen = 1'b1; sel = 2'd2; start = 1'b0; stop = 1'b0;
      start_addr = '0; end_addr = '0;

      // reset state
      #12;
      check("rst_rom_cs",    rom_cs,    1'b0);
      check("rst_rom_addr",  rom_addr,  16'h0000);
      check("rst_din",       din,       4'h0);
      check("rst_adpcm_rst", adpcm_rst, 1'b1);
      check("rst_busy",      busy,      1'b0);
      check("rst_done",      done,      1'b0);
      check("rst_err",       err,       1'b0);
      check("rst_cen_hf",    cen_hf,    1'b1);
      check("rst_cen_lo",    cen_lo,    1'b0);
      @(negedge clk);
      rst = 1'b0;

      // divider
      count_lo("div_sel2_first", 48);
      check("div_cen_hf", cen_hf, 1'b1);
      count_lo("div_sel2_second", 48);
      sel = 2'd1;
      repeat (60) @(negedge clk);
      sel = 2'd0;
      count_lo("div_sel0_midswitch", 36);
      count_lo("div_sel0_period", 96);
      sel = 2'd3;
      cnt_seen = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (cen_hf === 1'b1 || cen_lo === 1'b1) cnt_seen++;
      end
      check("div_sel3_quiet", cnt_seen, 0);
      sel = 2'd2;
      count_lo("div_sel3_resume", 48);

      // basic playback
      lat = 2;
      pulse_start(16'h0100, 16'h0101);
      check("basic_busy",     busy,     1'b1);
      check("basic_rom_cs",   rom_cs,   1'b1);
      check("basic_rom_addr", rom_addr, 16'h0100);
      play(1000, 16'h0102, nibs, nn, gap, hit_bad);
      check("basic_nibs",      nibs,      32'h3A5C);
      check("basic_count",     nn,        4);
      check("basic_done_gap",  gap,       1);
      check("basic_end_busy",  busy,      1'b0);
      check("basic_end_arst",  adpcm_rst, 1'b1);
      check("basic_end_din",   din,       4'h0);
      check("basic_no_0x102",  hit_bad,   1'b0);
      check("basic_err",       err,       1'b0);

      // guard: rom_ok stuck high, data lags the address by one cycle
      force_ok = 1'b1;
      pulse_start(16'h0300, 16'h0301);
      play(1000, 16'h0302, nibs, nn, gap, hit_bad);
      check("guard_nibs",  nibs, 32'hB4D6);
      check("guard_count", nn,   4);
      force_ok = 1'b0;

      // underrun with slow ROM
      lat = 200;
      pulse_start(16'h0200, 16'h0201);
      play(3000, 16'h0202, nibs, nn, gap, hit_bad);
      check("ur_stalled", (nn > 4) ? 1 : 0, 1);
      exp_nibs = (32'h71 << (4 * (nn - 2))) | 32'h9E;
      check("ur_nibs",     nibs, exp_nibs);
      check("ur_err",      err,  1'b1);
      check("ur_done_gap", gap,  1);

      // stop mid-play; err cleared by start
      lat = 2;
      pulse_start(16'h0100, 16'h0101);
      check("ctl_err_cleared", err, 1'b0);
      wait_tick("stop_reach_play");
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_busy",   busy,      1'b0);
      check("stop_arst",   adpcm_rst, 1'b1);
      check("stop_rom_cs", rom_cs,    1'b0);
      cnt_seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) cnt_seen++;
         @(negedge clk);
      end
      check("stop_no_done", cnt_seen, 0);

      // start and stop together
      start_addr = 16'h0100; end_addr = 16'h0101;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("both_busy",   busy,   1'b0);
      check("both_rom_cs", rom_cs, 1'b0);

      // start while busy
      pulse_start(16'h0100, 16'h0101);
      wait_tick("restart_reach_play");
      pulse_start(16'h0300, 16'h0301);
      check("restart_addr", rom_addr,  16'h0300);
      check("restart_busy", busy,      1'b1);
      check("restart_arst", adpcm_rst, 1'b1);
      play(1000, 16'h0302, nibs, nn, gap, hit_bad);
      check("restart_nibs", nibs, 32'hB4D6);

      // address wrap
      pulse_start(16'hFFFF, 16'h0000);
      play(1000, 16'h0001, nibs, nn, gap, hit_bad);
      check("wrap_nibs",    nibs,    32'h1248);
      check("wrap_count",   nn,      4);
      check("wrap_no_0001", hit_bad, 1'b0);

      // asynchronous reset mid-play
      pulse_start(16'h0100, 16'h0101);
      wait_tick("rst_reach_play");
      #2 rst = 1'b1;
      #1;
      check("arst_busy",     busy,      1'b0);
      check("arst_rom_cs",   rom_cs,    1'b0);
      check("arst_rom_addr", rom_addr,  16'h0000);
      check("arst_din",      din,       4'h0);
      check("arst_adpcm",    adpcm_rst, 1'b1);
      check("arst_done",     done,      1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
